// File: rtl/cpu_phase_sequencer.sv
// Purpose: sequences FETCH/EXEC/MEM/WB one-hot phase enables on one master clock, with run/step/halt control.
// Latency: 4 clocks per instruction nominal, +1 per dmem wait cycle; IDLE adds 1 clock between runs.
// Backpressure: mem_wait holds MEM up to WAIT_LIMIT extra cycles, then forces WB and sets mem_timeout.
module cpu_phase_sequencer #(
    parameter int CNT_W      = 32,
    parameter int WAIT_W     = 4,
    parameter int WAIT_LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_en,
    input  logic             step,
    input  logic             mem_wait,
    input  logic             halt_req,
    output logic             imem_en,
    output logic             proc_en,
    output logic             dmem_en,
    output logic             regfile_en,
    output logic [1:0]       phase,
    output logic             cycle_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic             mem_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                step_mode_q, step_mode_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                timeout_q, timeout_d;

    // State and bookkeeping registers; reset abandons any instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            step_mode_q <= 1'b0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            step_mode_q <= step_mode_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic: phase progression, dmem wait extension, retire and halt.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        step_mode_d = step_mode_q;
        count_d     = count_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (run_en) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d    = S_MEM;
                wait_cnt_d = '0;
            end
            S_MEM: begin
                if (!mem_wait) begin
                    state_d = S_WB;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    // dmem never answered: give up and retire anyway, flag it sticky
                    state_d   = S_WB;
                    timeout_d = 1'b1;
                end
            end
            S_WB: begin
                count_d = count_q + 1'b1;
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (run_en && !step_mode_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d     = S_IDLE;
                    step_mode_d = 1'b0;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode straight from the registered state.
    always_comb begin
        imem_en    = (state_q == S_FETCH);
        proc_en    = (state_q == S_EXEC);
        dmem_en    = (state_q == S_MEM);
        regfile_en = (state_q == S_WB);
        cycle_done = (state_q == S_WB);
        halted     = (state_q == S_HALTED);
        phase      = 2'b00;
        case (state_q)
            S_EXEC:  phase = 2'b01;
            S_MEM:   phase = 2'b10;
            S_WB:    phase = 2'b11;
            default: phase = 2'b00;
        endcase
    end

    assign instr_count = count_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Purpose: randomized plus directed stimulus for cpu_phase_sequencer against an instruction-level reference.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_wait patterns include short waits and stuck-high timeouts.
module tb_cpu_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset, run_en, step, mem_wait, halt_req;
    logic        imem_en, proc_en, dmem_en, regfile_en, cycle_done, halted, mem_timeout;
    logic [1:0]  phase;
    logic [31:0] instr_count;
    logic        imem_en3, proc_en3, dmem_en3, regfile_en3, cycle_done3, halted3, mem_timeout3;
    logic [1:0]  phase3;
    logic [2:0]  instr_count3;

    always #5 clock = ~clock;

    cpu_phase_sequencer #(.CNT_W(32), .WAIT_W(4), .WAIT_LIMIT(8)) dut (
        .clock(clock), .reset(reset), .run_en(run_en), .step(step),
        .mem_wait(mem_wait), .halt_req(halt_req),
        .imem_en(imem_en), .proc_en(proc_en), .dmem_en(dmem_en), .regfile_en(regfile_en),
        .phase(phase), .cycle_done(cycle_done), .instr_count(instr_count),
        .halted(halted), .mem_timeout(mem_timeout)
    );

    cpu_phase_sequencer #(.CNT_W(3), .WAIT_W(4), .WAIT_LIMIT(8)) dut3 (
        .clock(clock), .reset(reset), .run_en(run_en), .step(step),
        .mem_wait(mem_wait), .halt_req(halt_req),
        .imem_en(imem_en3), .proc_en(proc_en3), .dmem_en(dmem_en3), .regfile_en(regfile_en3),
        .phase(phase3), .cycle_done(cycle_done3), .instr_count(instr_count3),
        .halted(halted3), .mem_timeout(mem_timeout3)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: an instruction is "in flight" at some phase index 0..3,
    // MEM may be stretched by a number of extra cycles.
    bit          m_busy;
    int          m_pos;       // 0 fetch, 1 exec, 2 mem, 3 wb
    int          m_extra;     // extra MEM cycles spent on the current instruction
    bit          m_single;    // current instruction was launched by step
    bit          m_halt;
    bit          m_tout;
    int unsigned m_retired;

    task automatic model_edge(input bit r, input bit ru, input bit st, input bit mw, input bit hr);
        if (r) begin
            m_busy = 0; m_pos = 0; m_extra = 0; m_single = 0;
            m_halt = 0; m_tout = 0; m_retired = 0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (!m_busy) begin
            if (ru || st) begin
                m_busy = 1; m_pos = 0; m_single = !ru;
            end
        end else if (m_pos == 2) begin
            if (!mw) m_pos = 3;
            else if (m_extra < 8) m_extra++;
            else begin m_pos = 3; m_tout = 1; end
        end else if (m_pos == 3) begin
            m_retired++;
            if (hr) begin m_halt = 1; m_busy = 0; end
            else if (ru && !m_single) m_pos = 0;
            else begin m_busy = 0; m_single = 0; end
        end else begin
            m_pos++;
            if (m_pos == 2) m_extra = 0;
        end
    endtask

    task automatic compare_all();
        bit in_ph [4];
        for (int p = 0; p < 4; p++) in_ph[p] = m_busy && (m_pos == p);
        check("imem_en",     32'(imem_en),     32'(in_ph[0]));
        check("proc_en",     32'(proc_en),     32'(in_ph[1]));
        check("dmem_en",     32'(dmem_en),     32'(in_ph[2]));
        check("regfile_en",  32'(regfile_en),  32'(in_ph[3]));
        check("cycle_done",  32'(cycle_done),  32'(in_ph[3]));
        check("phase",       32'(phase),       m_busy ? 32'(m_pos) : 32'd0);
        check("halted",      32'(halted),      32'(m_halt));
        check("mem_timeout", 32'(mem_timeout), 32'(m_tout));
        check("instr_count", instr_count,      m_retired);
        check("count_w3",    32'(instr_count3), m_retired % 8);
        check("phase_w3",    32'(phase3),      m_busy ? 32'(m_pos) : 32'd0);
        check("halted_w3",   32'(halted3),     32'(m_halt));
    endtask

    // Apply one clock of inputs, advance the model at the edge, then sample.
    task automatic cyc(input bit r, input bit ru, input bit st, input bit mw, input bit hr);
        reset = r; run_en = ru; step = st; mem_wait = mw; halt_req = hr;
        @(posedge clock);
        model_edge(r, ru, st, mw, hr);
        #1;
        compare_all();
        @(negedge clock);
    endtask

    function automatic bit in_mem_below(input int n);
        return m_busy && m_pos == 2 && m_extra < n;
    endfunction

    int dmem_hi;
    int wbs;

    initial begin
        reset = 1; run_en = 0; step = 0; mem_wait = 0; halt_req = 0;
        m_busy = 0; m_pos = 0; m_extra = 0; m_single = 0;
        m_halt = 0; m_tout = 0; m_retired = 0;
        @(negedge clock);

        // 1: reset then free run
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        check("reset_count", instr_count, 32'd0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);

        // 2: three wait cycles on one instruction
        dmem_hi = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, in_mem_below(3) && m_retired == 5, 0);
            if (dmem_en) dmem_hi++;
        end
        check("wait3_mem_timeout", 32'(mem_timeout), 32'd0);

        // 3: mem_wait stuck high
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 1, 0);
        check("stuck_timeout", 32'(mem_timeout), 32'd1);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);

        // 4: paused stepping
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            cyc(0, 0, 1, 0, 0);
            for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
        end
        check("step_count", instr_count, 32'd3);
        // held step re-triggers once per IDLE visit
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 0);

        // 5: halt in second WB
        cyc(1, 0, 0, 0, 0);
        wbs = 0;
        for (int i = 0; i < 30; i++) begin
            bit h;
            h = m_busy && m_pos == 3 && wbs == 1;
            if (m_busy && m_pos == 3) wbs++;
            cyc(0, (i < 12), (i >= 12), 1, h);
        end
        check("halt_count", instr_count, 32'd2);
        cyc(1, 1, 0, 0, 0);

        // 6: reset during MEM, then wrap on the narrow counter
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0);
        while (!(m_busy && m_pos == 2)) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0);

        // randomized stretch
        for (int i = 0; i < 4000; i++) begin
            bit r, ru, st, mw, hr;
            r  = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 15) == 0);
            ru = ($urandom_range(0, 3) != 0) ^ (i[9]);
            st = ($urandom_range(0, 5) == 0);
            mw = (i % 700 > 650) ? 1'b1 : ($urandom_range(0, 2) == 0);
            hr = ($urandom_range(0, 24) == 0);
            cyc(r, ru, st, mw, hr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
